// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Access-size codes and the read-modify-write FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  function automatic logic is_sub(input logic [1:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte/half lane logic: merges store data into a word
// and extracts plus extends load data from a word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merge_o,
  output logic [31:0] load_o
);

  logic [4:0]  b_sh;
  logic [4:0]  h_sh;
  logic [7:0]  b_v;
  logic [15:0] h_v;

  // Half accesses only look at lane bit 1
  assign b_sh = {lane_i, 3'b000};
  assign h_sh = {lane_i[1], 4'b0000};
  assign b_v  = rdata_i[b_sh +: 8];
  assign h_v  = rdata_i[h_sh +: 16];

  always_comb begin
    merge_o = rdata_i;
    unique case (size_i)
      SZ_BYTE: merge_o[b_sh +: 8]  = wdata_i[7:0];
      SZ_HALF: merge_o[h_sh +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

  always_comb begin
    unique case (size_i)
      SZ_BYTE: load_o = {{24{~uns_i & b_v[7]}}, b_v};
      SZ_HALF: load_o = {{16{~uns_i & h_v[15]}}, h_v};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: word-only data_memory, sub-word stores via RMW.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_reg_write,
  input  logic [4:0]        in_rd,
  output logic              stall,
  output logic [ADDR_W-1:0] dm_address,
  output logic              dm_read_e,
  output logic              dm_write_e,
  output logic [DATA_W-1:0] dm_write_data,
  input  logic [DATA_W-1:0] dm_read_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misaligned
);

  lsu_state_e          st_q, st_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   ld_data;
  logic                misal;
  logic                ld;
  logic                st;
  logic                rmw_start;
  logic                rd_e;
  logic                wr_e;

  logic                valid_d;
  logic                rw_d;
  logic [4:0]          rd_d;
  logic [DATA_W-1:0]   data_d;
  logic                mis_q;

  assign dm_address = in_addr[ADDR_W+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_half;
  logic is_word;
  assign is_half = (in_size == SZ_HALF);
  assign is_word = !is_sub(in_size);
  assign misal = in_valid & (in_mem_read | in_mem_write)
               & ((is_half & in_addr[0])
               | (is_word & (in_addr[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign ld        = in_valid & in_mem_read & ~misal;
  assign st        = in_valid & in_mem_write & ~misal;
  assign rmw_start = st & is_sub(in_size);

  lsu_byte_lane u_lane (
    .size_i  (in_size),
    .uns_i   (in_unsigned),
    .lane_i  (in_addr[1:0]),
    .rdata_i (dm_read_data),
    .wdata_i (in_wdata),
    .merge_o (merged),
    .load_o  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (rmw_start) st_d = RMW_WR;
      RMW_WR:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    rd_e          = 1'b0;
    wr_e          = 1'b0;
    stall         = 1'b0;
    dm_write_data = in_wdata;
    unique case (st_q)
      IDLE: begin
        if (ld) begin
          rd_e = 1'b1;
        end else if (rmw_start) begin
          rd_e  = 1'b1;
          stall = 1'b1;
        end else if (st) begin
          wr_e = 1'b1;
        end
      end
      RMW_WR: begin
        wr_e          = 1'b1;
        dm_write_data = merge_q;
      end
      default: ;
    endcase
  end

  // Enables drop the moment reset rises, not at the next edge
  assign dm_read_e  = rd_e & ~rst;
  assign dm_write_e = wr_e & ~rst;

  always_comb begin
    merge_d = merge_q;
    valid_d = in_valid;
    rw_d    = in_reg_write & ~in_mem_write & ~misal;
    rd_d    = in_rd;
    data_d  = ld ? ld_data : in_addr;
    if (st_q == IDLE && rmw_start) begin
      merge_d = merged;
      valid_d = 1'b0;
      rw_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_q      <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mis_q        <= 1'b0;
    end else begin
      merge_q      <= merge_d;
      wb_valid     <= valid_d;
      wb_reg_write <= rw_d;
      wb_rd        <= rd_d;
      wb_data      <= data_d;
      mis_q        <= misal;
    end
  end

  assign wb_misaligned = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a 128-word memory model.
// Build with LSU_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic        stall;
  logic [6:0]  dm_address;
  logic        dm_read_e;
  logic        dm_write_e;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  logic [31:0] mem [0:127];
  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_lsu #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .stall         (stall),
    .dm_address    (dm_address),
    .dm_read_e     (dm_read_e),
    .dm_write_e    (dm_write_e),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_misaligned (wb_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (dm_write_e) mem[dm_address] <= dm_write_data;
  assign dm_read_data = mem[dm_address];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic r,
                     input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic rw, input logic [4:0] rd);
    @(negedge clk);
    in_valid     = v;
    in_mem_read  = r;
    in_mem_write = w;
    in_size      = sz;
    in_unsigned  = u;
    in_addr      = a;
    in_wdata     = wd;
    in_reg_write = rw;
    in_rd        = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_size      = 2'b00;
    in_unsigned  = 1'b0;
    in_addr      = '0;
    in_wdata     = '0;
    in_reg_write = 1'b0;
    in_rd        = '0;
    #12;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // word store then load
    drv(1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    chk("sw_we", {31'b0, dm_write_e}, 32'h1);
    chk("sw_addr", {25'b0, dm_address}, 32'h4);
    chk("sw_wdata", dm_write_data, 32'hDEADBEEF);
    chk("sw_stall", {31'b0, stall}, 32'h0);
    tick();
    drv(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 5'd5);
    chk("lw_re", {31'b0, dm_read_e}, 32'h1);
    chk("lw_addr", {25'b0, dm_address}, 32'h4);
    tick();
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rw", {31'b0, wb_reg_write}, 32'h1);
    chk("lw_rd", {27'b0, wb_rd}, 32'd5);

    // SB 0x11
    drv(1, 0, 1, 2'b00, 0, 32'h11, 32'h55, 1, 5'd3);
    chk("sb_stall", {31'b0, stall}, 32'h1);
    chk("sb_re", {31'b0, dm_read_e}, 32'h1);
    chk("sb_we0", {31'b0, dm_write_e}, 32'h0);
    tick();
    chk("sb_bubble", {31'b0, wb_valid}, 32'h0);
    chk("sb_stall2", {31'b0, stall}, 32'h0);
    chk("sb_we1", {31'b0, dm_write_e}, 32'h1);
    chk("sb_wdata", dm_write_data, 32'hDEAD55EF);
    tick();
    chk("sb_wbv", {31'b0, wb_valid}, 32'h1);
    chk("sb_wbrw", {31'b0, wb_reg_write}, 32'h0);
    chk("sb_mem", mem[4], 32'hDEAD55EF);
    drv(1, 1, 0, 2'b00, 1, 32'h11, 32'h0, 1, 5'd6);
    tick();
    chk("lbu_11", wb_data, 32'h00000055);
    drv(1, 1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 5'd6);
    tick();
    chk("lb_13", wb_data, 32'hFFFFFFDE);

    // SH 0x12
    drv(1, 0, 1, 2'b01, 0, 32'h12, 32'h8001, 0, 0);
    chk("sh_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("sh_wdata", dm_write_data, 32'h800155EF);
    tick();
    chk("sh_mem", mem[4], 32'h800155EF);
    drv(1, 1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 5'd7);
    tick();
    chk("lh_12", wb_data, 32'hFFFF8001);
    drv(1, 1, 0, 2'b01, 1, 32'h12, 32'h0, 1, 5'd7);
    tick();
    chk("lhu_12", wb_data, 32'h00008001);

    // reset during RMW_WR
    drv(1, 0, 1, 2'b00, 0, 32'h10, 32'hAA, 0, 5'd2);
    tick();
    chk("rmw_we", {31'b0, dm_write_e}, 32'h1);
    chk("rmw_wdata", dm_write_data, 32'h800155AA);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", {31'b0, dm_write_e}, 32'h0);
    chk("arst_wbv", {31'b0, wb_valid}, 32'h0);
    chk("arst_wbrw", {31'b0, wb_reg_write}, 32'h0);
    chk("arst_wbrd", {27'b0, wb_rd}, 32'h0);
    chk("arst_wbd", wb_data, 32'h0);
    tick();
    chk("arst_mem", mem[4], 32'h800155EF);
    drv(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0);
    rst = 1'b0;

    // LW 0x13
    drv(1, 1, 0, 2'b10, 0, 32'h13, 32'h0, 1, 5'd8);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_re", {31'b0, dm_read_e}, 32'h0);
    chk("mis_we", {31'b0, dm_write_e}, 32'h0);
    tick();
    chk("mis_flag", {31'b0, wb_misaligned}, 32'h1);
    chk("mis_rw", {31'b0, wb_reg_write}, 32'h0);
    drv(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0);
    tick();
    chk("mis_clr", {31'b0, wb_misaligned}, 32'h0);
`else
    chk("lw13_re", {31'b0, dm_read_e}, 32'h1);
    chk("lw13_addr", {25'b0, dm_address}, 32'h4);
    tick();
    chk("lw13_data", wb_data, 32'h800155EF);
    chk("lw13_mis", {31'b0, wb_misaligned}, 32'h0);
`endif

    // non-memory op
    drv(1, 0, 0, 2'b00, 0, 32'h1234, 32'h0, 1, 5'd9);
    chk("add_stall", {31'b0, stall}, 32'h0);
    chk("add_en", {30'b0, dm_read_e, dm_write_e}, 32'h0);
    tick();
    chk("add_data", wb_data, 32'h1234);
    chk("add_rw", {31'b0, wb_reg_write}, 32'h1);
    chk("add_rd", {27'b0, wb_rd}, 32'd9);
    drv(1, 0, 0, 2'b00, 0, 32'hABCD, 32'h0, 0, 5'd4);
    tick();
    chk("nop_rw", {31'b0, wb_reg_write}, 32'h0);
    chk("nop_data", wb_data, 32'hABCD);

    // address wrap modulo 512 bytes
    drv(1, 1, 0, 2'b10, 0, 32'h210, 32'h0, 1, 5'd1);
    chk("wrap_addr", {25'b0, dm_address}, 32'h4);
    tick();
    chk("wrap_data", wb_data, 32'h800155EF);

    // invalid sub-word store does nothing
    drv(0, 0, 1, 2'b00, 0, 32'h10, 32'h11, 0, 0);
    chk("inv_stall", {31'b0, stall}, 32'h0);
    chk("inv_en", {30'b0, dm_read_e, dm_write_e}, 32'h0);
    tick();
    chk("inv_wbv", {31'b0, wb_valid}, 32'h0);
    chk("inv_mem", mem[4], 32'h800155EF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
